// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared encodings for the accumulator execute stage
//
// Purpose: ALU function codes, FSM state type and the bundle of control bits
// that travel with an instruction into the MEM stage.
// Ports: none (package).

package ex_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  // Controls forwarded to MEM, MSB first: wr, wm, rm, neq, j, jc
  typedef struct packed {
    logic wr;
    logic wm;
    logic rm;
    logic neq;
    logic j;
    logic jc;
  } mem_ctl_t;

endpackage

// File: rtl/ex_mul_seq.sv
// rtl/ex_mul_seq.sv - sequential shift-add multiplier, low half of the product
//
// Purpose: DATA_W-step shift-add multiply; one step per clock after start.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start             load operands a/b and begin (ignored while abort)
//   abort             cancel any multiply in progress
//   a, b              multiplicand / multiplier
//   done              high during the cycle whose step is the last one
//   product           low DATA_W bits; valid while done and until next start

module ex_mul_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] acc_step;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
    end
  end

  // The final step's sum is offered combinationally so a free output
  // register can capture it on the same edge the step completes.
  assign done    = (cnt_q == CNT_W'(1));
  assign product = (cnt_q != '0) ? acc_step : acc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// rtl/ex_stage_pipe.sv - execute stage with accumulator and EX/MEM register
//
// Purpose: ALU against the internal accumulator, jump target, optional
// multi-cycle multiply, and the EX/MEM pipeline register with valid/ready.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready          decode-side handshake
//   flush                        kill in-flight and incoming instruction
//   wr sout wm rm neq j jc sin ina, pc, reg_val, sinal_ext, funct
//                                decoded instruction fields
//   out_valid / out_ready        MEM-side handshake
//   busy                         multiply in progress
//   zero_out, ac_out_value, ula_jump_out, rs, *_mem
//                                EX/MEM register contents

module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              wr,
  input  logic              sout,
  input  logic              wm,
  input  logic              rm,
  input  logic              neq,
  input  logic              j,
  input  logic              jc,
  input  logic              sin,
  input  logic              ina,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] reg_val,
  input  logic [DATA_W-1:0] sinal_ext,
  input  logic [2:0]        funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              zero_out,
  output logic [DATA_W-1:0] ac_out_value,
  output logic [PC_W-1:0]   ula_jump_out,
  output logic [DATA_W-1:0] rs,
  output logic              wr_mem,
  output logic              wm_mem,
  output logic              rm_mem,
  output logic              neq_mem,
  output logic              j_mem,
  output logic              jc_mem
);

  localparam int SH_W = $clog2(DATA_W);

  ex_state_e         state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic [PC_W-1:0]   jump_q, jump_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  mem_ctl_t          ctl_q, ctl_d;

  // Fields of the multiply in flight, captured at accept time
  logic [PC_W-1:0]   pjump_q, pjump_d;
  logic [DATA_W-1:0] prs_q, prs_d;
  mem_ctl_t          pctl_q, pctl_d;

  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [PC_W-1:0]   imm_pc;
  logic [PC_W-1:0]   jump_in;
  mem_ctl_t          ctl_in;
  logic              accept;
  logic              reg_free;
  logic              is_mul;
  logic              load_mul;
  logic              mul_start;
  logic              mul_abort;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  if (PC_W > DATA_W) begin : g_imm_sext
    assign imm_pc = {{(PC_W - DATA_W){sinal_ext[DATA_W-1]}}, sinal_ext};
  end else begin : g_imm_trunc
    assign imm_pc = sinal_ext[PC_W-1:0];
  end

  assign jump_in  = pc + imm_pc;
  assign ctl_in   = {wr, wm, rm, neq, j, jc};
  assign busy     = (state_q != ST_IDLE);
  assign reg_free = !out_valid_q || out_ready;
  assign in_ready = !busy && reg_free && !reset;
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (funct == ALU_MUL) && !ina;

  always_comb begin
    op_b    = sin ? sinal_ext : reg_val;
    alu_res = acc_q;
    case (funct)
      ALU_ADD: alu_res = acc_q + op_b;
      ALU_SUB: alu_res = acc_q - op_b;
      ALU_AND: alu_res = acc_q & op_b;
      ALU_OR:  alu_res = acc_q | op_b;
      ALU_XOR: alu_res = acc_q ^ op_b;
      ALU_SHL: alu_res = acc_q << op_b[SH_W-1:0];
      ALU_SHR: alu_res = acc_q >> op_b[SH_W-1:0];
      // With the multiplier present this path is unused; without it, pass A
      default: alu_res = acc_q;
    endcase
    if (ina) begin
      alu_res = op_b;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    zero_d      = zero_q;
    jump_d      = jump_q;
    rs_d        = rs_q;
    ctl_d       = ctl_q;
    pjump_d     = pjump_q;
    prs_d       = prs_q;
    pctl_d      = pctl_q;
    mul_start   = 1'b0;
    mul_abort   = 1'b0;
    load_mul    = 1'b0;

    if (flush) begin
      // Register payload is left alone; only validity and MEM controls die
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      ctl_d       = '0;
      mul_abort   = 1'b1;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mul_start = 1'b1;
              pjump_d   = jump_in;
              prs_d     = sout ? acc_q : reg_val;
              pctl_d    = ctl_in;
              state_d   = ST_MUL;
            end else begin
              out_valid_d = 1'b1;
              res_d       = alu_res;
              zero_d      = (alu_res == '0);
              jump_d      = jump_in;
              rs_d        = sout ? acc_q : reg_val;
              ctl_d       = ctl_in;
              if (wr) begin
                acc_d = alu_res;
              end
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            if (reg_free) begin
              load_mul = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (reg_free) begin
            load_mul = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (load_mul) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b1;
        res_d       = mul_product;
        zero_d      = (mul_product == '0);
        jump_d      = pjump_q;
        rs_d        = prs_q;
        ctl_d       = pctl_q;
        if (pctl_q.wr) begin
          acc_d = mul_product;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      jump_q      <= '0;
      rs_q        <= '0;
      ctl_q       <= '0;
      pjump_q     <= '0;
      prs_q       <= '0;
      pctl_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      jump_q      <= jump_d;
      rs_q        <= rs_d;
      ctl_q       <= ctl_d;
      pjump_q     <= pjump_d;
      prs_q       <= prs_d;
      pctl_q      <= pctl_d;
    end
  end

  ex_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (acc_q),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  assign out_valid    = out_valid_q;
  assign zero_out     = zero_q;
  assign ac_out_value = res_q;
  assign ula_jump_out = jump_q;
  assign rs           = rs_q;
  assign wr_mem       = ctl_q.wr;
  assign wm_mem       = ctl_q.wm;
  assign rm_mem       = ctl_q.rm;
  assign neq_mem      = ctl_q.neq;
  assign j_mem        = ctl_q.j;
  assign jc_mem       = ctl_q.jc;

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Parametrised execute stage for the accumulator processor. It sits between decode and memory. It computes ALU results against an internal accumulator, computes the jump target, and owns the EX/MEM pipeline register. It adds generic data/PC widths, a valid/ready handshake with back-pressure, flush, and an optional multi-cycle multiplier.

Parameters:
DATA_W, 8, accumulator/operand/result width (>=4, power of two)
PC_W, 8, program counter / jump target width
MUL_EN, 1, 1 = funct 111 is a multi-cycle multiply; 0 = funct 111 passes accumulator unchanged

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts an instruction this cycle
flush  in  1  kill in-flight/incoming instruction (taken jump)
wr sout wm rm neq j jc sin ina  in  1 each  decoded control bits
pc  in  PC_W  PC of the instruction
reg_val  in  DATA_W  register-file operand
sinal_ext  in  DATA_W  sign-extended immediate
funct  in  3  ALU op select
out_valid  out  1  EX/MEM register holds a valid instruction
out_ready  in  1  MEM stage consumes the register
busy  out  1  multiplier running
zero_out  out  1  result == 0
ac_out_value  out  DATA_W  ALU result
ula_jump_out  out  PC_W  jump target
rs  out  DATA_W  store/output data
wr_mem wm_mem rm_mem neq_mem j_mem jc_mem  out  1 each  controls forwarded to MEM

Behaviour:
- Reset: all outputs and the accumulator are 0. State is IDLE. in_ready becomes 1 on the first cycle after reset is deasserted.
- Operand B = sin ? sinal_ext : reg_val. Operand A = current accumulator.
- funct: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL A by B[log2(DATA_W)-1:0], 110 SHR (logical), 111 MUL low half or pass-A.
- ina=1 forces result = B (load) regardless of funct.
- All arithmetic wraps modulo 2^DATA_W. No flags other than zero.
- ula_jump_out = pc + sinal_ext, with sinal_ext sign-extended or truncated to PC_W; wraps modulo 2^PC_W.
- rs = sout ? accumulator value before this instruction : reg_val.
- Handshake: accept = in_valid && in_ready. in_ready = !busy && (!out_valid || out_ready) && !reset.
- Single-cycle op: latency 1. On accept the EX/MEM register loads result, zero, jump, rs and controls; out_valid=1 next cycle. If wr=1, the accumulator is written at the same edge, so the next accepted instruction sees the new value (no bubble).
- Hold: while out_valid && !out_ready, all outputs stay stable.
- Consume: out_ready with no new accept drops out_valid to 0. out_ready together with accept replaces the register contents in the same edge.
- FSM states:
  - IDLE to MUL on accept of funct=111, ina=0, MUL_EN=1: latch A, B and controls; busy=1; counter=DATA_W.
  - MUL: one shift-add step per cycle.
  - MUL to DONE when counter reaches 0.
  - DONE to IDLE once the output register is free (!out_valid || out_ready). At that point load the register, write the accumulator if wr, and set busy=0.
  - Minimum MUL latency from accept to out_valid is DATA_W+1 cycles.
- Flush (synchronous, precedence over all but reset):
  - clears out_valid and all *_mem controls to 0;
  - aborts MUL/DONE back to IDLE with busy=0;
  - drops an instruction offered in the same cycle;
  - the accumulator is not updated by any flushed instruction, including a single-cycle op accepted that cycle.
- Reset mid-MUL behaves identically to power-on reset.

Decomposition:
- Shared package ex_pkg holds the funct encodings (ALU_ADD..ALU_MUL) and FSM state constants.
- One sub-module, ex_mul_seq: sequential shift-add multiplier with start/done and an abort input. The ALU, accumulator and pipeline register stay in ex_stage_pipe.

Test Plan:
- Load, then add (DATA_W=8): accept ina=1,sin=1,wr=1,sinal_ext=7. Then sin=0,funct=000,reg_val=1,wr=1. Result: ac_out_value 7 then 8, zero_out 0, back-to-back with no bubble.
- Jump and SUB to zero: pc=6, sinal_ext=8'h3F, j=1, funct=001, A=B=3. Result: ula_jump_out=69, zero_out=1, j_mem=1 one cycle after accept.
- Back-pressure: hold out_ready=0 for 3 cycles with in_valid=1. Outputs stay stable and in_ready=0. Raising out_ready accepts the next instruction the same cycle.
- Multiply: A=13, B=11, funct=111, wr=1. busy stays high 8 cycles; out_valid rises at cycle 9; ac_out_value=143. A second multiply A=143, B=2 gives 30 (wrap).
- Flush mid-MUL at cycle 4: busy drops the next cycle, out_valid stays 0, the accumulator keeps its prior value, and in_ready returns to 1.
- Reset during hold with out_valid=1: all outputs and the accumulator read 0 next cycle, and in_ready=1 the cycle after reset deasserts.
